// File: rtl/button_pkg.sv
// Shared definitions for the push-button front end (button_debounce, button_event):
// FSM encodings, default hold timings and the common 2 ms tick period.
package button_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2,
        ST_REPEAT  = 2'd3
    } btn_state_e;

    localparam int LONG_TICKS_DEF   = 500;
    localparam int REPEAT_TICKS_DEF = 100;
    // 2 ms at the 12 MHz board clock
    localparam int TICK_PERIOD_CLKS = 24000;

endpackage

// File: rtl/tick_counter.sv
// Hold-time counter in debounce ticks; o_hit flags the tick that reaches i_limit.
module tick_counter
    import button_pkg::*;
#(
    parameter int CNT_W = 10
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_ena,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_hit
);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_inc_s;

    assign count_inc_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    assign o_hit       = i_ena & (count_inc_s == i_limit);

    // Count register; clear wins over a simultaneous tick
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (i_clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (i_ena) begin
            count_r <= count_inc_s;
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/button_event.sv
// Turns the debounced button level into press/release/long/repeat strobes.
// Auto-repeat is compiled in only when BUTTON_EVENT_REPEAT_EN is defined.
module button_event
    import button_pkg::*;
#(
    parameter int LONG_TICKS   = LONG_TICKS_DEF,
    parameter int REPEAT_TICKS = REPEAT_TICKS_DEF,
    parameter int CNT_W        = 10
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_ena,
    input  logic i_q,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_repeat,
    output logic o_held
);

    localparam logic [CNT_W-1:0] LONG_LIM = LONG_TICKS[CNT_W-1:0];

    btn_state_e       state_r;
    btn_state_e       state_nxt_s;
    logic             q_d_r;
    logic             rise_s;
    logic             fall_s;
    logic             cnt_clr_s;
    logic             cnt_ena_s;
    logic [CNT_W-1:0] cnt_limit_s;
    logic             hit_s;
    logic             press_s;
    logic             release_s;
    logic             long_s;
    logic             held_s;

    assign rise_s = i_q & ~q_d_r;
    assign fall_s = ~i_q & q_d_r;

`ifdef BUTTON_EVENT_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LIM = REPEAT_TICKS[CNT_W-1:0];
    logic repeat_s;
    assign cnt_limit_s = (state_r == ST_REPEAT) ? REPEAT_LIM : LONG_LIM;
    assign cnt_ena_s   = i_ena & ~fall_s & ((state_r == ST_PRESSED) | (state_r == ST_REPEAT));
`else
    assign cnt_limit_s = LONG_LIM;
    assign cnt_ena_s   = i_ena & ~fall_s & (state_r == ST_PRESSED);
`endif

    tick_counter #(
        .CNT_W (CNT_W)
    ) u_tick_counter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (cnt_clr_s),
        .i_ena   (cnt_ena_s),
        .i_limit (cnt_limit_s),
        .o_hit   (hit_s)
    );

    // Next-state and strobe decode; a release pre-empts any tick in the same cycle
    always_comb begin
        state_nxt_s = state_r;
        press_s     = 1'b0;
        release_s   = 1'b0;
        long_s      = 1'b0;
        cnt_clr_s   = 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
        repeat_s    = 1'b0;
`endif
        if ((state_r != ST_IDLE) && fall_s) begin
            release_s   = 1'b1;
            cnt_clr_s   = 1'b1;
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rise_s) begin
                        press_s     = 1'b1;
                        cnt_clr_s   = 1'b1;
                        state_nxt_s = ST_PRESSED;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    if (hit_s) begin
                        long_s    = 1'b1;
                        cnt_clr_s = 1'b1;
`ifdef BUTTON_EVENT_REPEAT_EN
                        state_nxt_s = ST_REPEAT;
`else
                        state_nxt_s = ST_HELD;
`endif
                    end else begin
                        state_nxt_s = ST_PRESSED;
                    end
                end
                ST_HELD: begin
                    state_nxt_s = ST_HELD;
                end
                ST_REPEAT: begin
`ifdef BUTTON_EVENT_REPEAT_EN
                    if (hit_s) begin
                        repeat_s  = 1'b1;
                        cnt_clr_s = 1'b1;
                    end else begin
                        cnt_clr_s = 1'b0;
                    end
                    state_nxt_s = ST_REPEAT;
`else
                    // Unreachable without auto-repeat; recover to a known state
                    cnt_clr_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
`endif
                end
                default: begin
                    cnt_clr_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    assign held_s = (state_nxt_s == ST_HELD) | (state_nxt_s == ST_REPEAT);

    // Input delay, state and registered event outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            q_d_r     <= 1'b0;
            state_r   <= ST_IDLE;
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_long    <= 1'b0;
            o_held    <= 1'b0;
        end else begin
            q_d_r     <= i_q;
            state_r   <= state_nxt_s;
            o_press   <= press_s;
            o_release <= release_s;
            o_long    <= long_s;
            o_held    <= held_s;
        end
    end

`ifdef BUTTON_EVENT_REPEAT_EN
    // Registered auto-repeat strobe
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_repeat <= 1'b0;
        end else begin
            o_repeat <= repeat_s;
        end
    end
`else
    assign o_repeat = 1'b0;
`endif

endmodule
